muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers, sitting beside the Execute-stage ALU.
- It is the requester side of stall control. It drives `md_busy` to the hazard logic, which stalls Decode on MFHI/MFLO/MTHI/MTLO/MULT/DIV while `md_busy` is high.
- It accepts one operation per idle period and accepts abort from the flush path.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_divstep.sv | 19 +
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, divide-by-zero fill.
package mdu_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Divide by zero: every quotient bit is set; HI returns the dividend as given.
  localparam logic MD_DIV0_FILL = 1'b1;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-divide step: shifted partial remainder vs. divisor -> next remainder, quotient bit.
// Purely combinational; used once per RUN cycle.
module mdu_divstep #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   prem_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_o
);

  logic [DATA_W-1:0] sub;

  // The remainder stays below the divisor, so the difference always fits in DATA_W bits.
  assign sub   = prem_i[DATA_W-1:0] - divisor_i;
  assign q_o   = (prem_i >= {1'b0, divisor_i});
  assign rem_o = q_o ? sub : prem_i[DATA_W-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; 33 cycles busy per op, md_busy stalls Decode.
// MULDIV_FAST_MUL_EN: multiplies use a native multiplier and finish in one busy cycle.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_e,
  input  logic [1:0]        op_e,
  input  logic [DATA_W-1:0] src_a_e,
  input  logic [DATA_W-1:0] src_b_e,
  input  logic              abort,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              md_busy,
  output logic              md_done
);

  localparam int W2 = 2 * DATA_W;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              is_div_q, is_div_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              div0_q, div0_d;
  logic              done_q, done_d;

  logic              op_signed, op_is_div, a_neg, b_neg;
  logic [DATA_W-1:0] abs_a, abs_b;

  assign op_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign op_is_div = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign a_neg     = op_signed & src_a_e[DATA_W-1];
  assign b_neg     = op_signed & src_b_e[DATA_W-1];
  assign abs_a     = a_neg ? -src_a_e : src_a_e;
  assign abs_b     = b_neg ? -src_b_e : src_b_e;

  // Multiply: acc = {partial product, remaining multiplier bits}, add and shift right.
  logic [DATA_W-1:0] mul_addend;
  logic [DATA_W:0]   mul_sum;
  logic [W2-1:0]     mul_next;

  assign mul_addend = acc_q[0] ? opb_q : '0;
  assign mul_sum    = {1'b0, acc_q[W2-1:DATA_W]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [DATA_W-1:0] div_rem;
  logic              div_qbit;
  logic [W2-1:0]     div_next;

  mdu_divstep #(.DATA_W(DATA_W)) u_divstep (
    .prem_i    (acc_q[W2-1:DATA_W-1]),
    .divisor_i (opb_q),
    .rem_o     (div_rem),
    .q_o       (div_qbit)
  );

  assign div_next = {div_rem, acc_q[DATA_W-2:0], div_qbit};

`ifdef MULDIV_FAST_MUL_EN
  logic [W2-1:0] fast_prod;
  assign fast_prod = W2'(abs_a) * W2'(abs_b);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_e && !abort) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          is_div_d = op_is_div;
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = op_is_div & a_neg;
          div0_d   = op_is_div & (src_b_e == '0);
          if (op_is_div) begin
            acc_d = {{DATA_W{1'b0}}, abs_a};
            opb_d = abs_b;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            acc_d   = fast_prod;
            state_d = ST_FIX;
`else
            acc_d = {{DATA_W{1'b0}}, abs_b};
`endif
            opb_d = abs_a;
          end
        end else if (!start_e) begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '1) state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = div0_q ? {DATA_W{MD_DIV0_FILL}}
                          : (qneg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]);
            // With a zero divisor the remainder is |a|, so re-signing it restores a.
            hi_d = rneg_q ? -acc_q[W2-1:DATA_W] : acc_q[W2-1:DATA_W];
          end else begin
            {hi_d, lo_d} = qneg_q ? -acc_q : acc_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign md_busy = (state_q != ST_IDLE);
  assign md_done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a queue of expected {hi,lo} is checked on every md_done.
module tb_muldiv_unit;
  import mdu_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_e = 1'b0;
  logic [1:0]  op_e = 2'b00;
  logic [31:0] src_a_e = '0;
  logic [31:0] src_b_e = '0;
  logic        abort = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        md_busy, md_done;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  muldiv_unit #(.DATA_W(32), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_e (start_e),
    .op_e    (op_e),
    .src_a_e (src_a_e),
    .src_b_e (src_b_e),
    .abort   (abort),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .hi      (hi),
    .lo      (lo),
    .md_busy (md_busy),
    .md_done (md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every md_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && md_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result_hi", {32'h0, hi}, {32'h0, mon_exp[63:32]});
        chk("result_lo", {32'h0, lo}, {32'h0, mon_exp[31:0]});
      end
    end
  end

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int exp_busy);
    int n;
    @(negedge clk);
    start_e = 1'b1; op_e = op; src_a_e = a; src_b_e = b;
    exp_q.push_back(exp);
    @(negedge clk);
    start_e = 1'b0;
    n = 0;
    while (md_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    chk({name, "_done_pulse"}, {63'h0, md_done}, 64'h1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    repeat (2) @(negedge clk);
    chk("reset_hi",   {32'h0, hi}, 64'h0);
    chk("reset_lo",   {32'h0, lo}, 64'h0);
    chk("reset_busy", {63'h0, md_busy}, 64'h0);
    chk("reset_done", {63'h0, md_done}, 64'h0);
    rst_n = 1'b1;

    do_op("mult_m3x7",   MD_MULT,  32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, MUL_BUSY);
    do_op("multu_max",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_BUSY);
    do_op("multu_shift", MD_MULTU, 32'h1234_5678, 32'h10,       64'h0000_0001_2345_6780, MUL_BUSY);
    do_op("div_m7d2",    MD_DIV,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, DIV_BUSY);
    do_op("div_7dm2",    MD_DIV,   32'd7,        32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, DIV_BUSY);
    do_op("div_ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_BUSY);
    do_op("divu_100d0",  MD_DIVU,  32'd100,      32'd0,         64'h0000_0064_FFFF_FFFF, DIV_BUSY);
    do_op("div_m8d0",    MD_DIV,   32'hFFFF_FFF8, 32'd0,        64'hFFFF_FFF8_FFFF_FFFF, DIV_BUSY);
    do_op("divu_big",    MD_DIVU,  32'hFFFF_FFFF, 32'd16,       64'h0000_000F_0FFF_FFFF, DIV_BUSY);

    // MTHI+MTLO together, then MTLO alone.
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_ABCD;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both_hi", {32'h0, hi}, 64'h0000_ABCD);
    chk("mt_both_lo", {32'h0, lo}, 64'h0000_ABCD);
    mtlo = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk); mtlo = 1'b0;
    chk("mtlo_lo", {32'h0, lo}, 64'h0000_1234);
    chk("mtlo_hi", {32'h0, hi}, 64'h0000_ABCD);

    // DIVU 50/5 with an ignored restart at cycle 5 and an abort at cycle 10.
    @(negedge clk); start_e = 1'b1; op_e = MD_DIVU; src_a_e = 32'd50; src_b_e = 32'd5;
    @(negedge clk); start_e = 1'b0;
    repeat (3) @(negedge clk);
    start_e = 1'b1; op_e = MD_MULTU; src_a_e = 32'd3; src_b_e = 32'd3;
    @(negedge clk); start_e = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", {63'h0, md_busy}, 64'h1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy_after", {63'h0, md_busy}, 64'h0);
    chk("abort_lo", {32'h0, lo}, 64'h0000_1234);
    chk("abort_hi", {32'h0, hi}, 64'h0000_ABCD);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done || md_busy) dones++;
    end
    chk("abort_no_done_or_busy", 64'(dones), 64'h0);

    // Reset in the middle of MULT 5x5.
    @(negedge clk); start_e = 1'b1; op_e = MD_MULT; src_a_e = 32'd5; src_b_e = 32'd5;
    @(negedge clk); start_e = 1'b0;
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi",   {32'h0, hi}, 64'h0);
    chk("midrst_lo",   {32'h0, lo}, 64'h0);
    chk("midrst_busy", {63'h0, md_busy}, 64'h0);
    chk("midrst_done", {63'h0, md_done}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    do_op("mult_5x5", MD_MULT, 32'd5, 32'd5, 64'h0000_0000_0000_0019, MUL_BUSY);

    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
